// File: rtl/usb_token_tx_if.sv
// Token request and serial beat bundle for usb_token_tx.
// slave  : the token builder (consumes tokens, produces beats)
// master : the requester / downstream sink that drives it
interface usb_token_tx_if #(
    parameter int BEAT_W = 1
);
    logic              tok_valid;
    logic              tok_ready;
    logic [3:0]        tok_pid;
    logic [6:0]        tok_addr;
    logic [3:0]        tok_endp;

    logic              tx_valid;
    logic              tx_ready;
    logic [BEAT_W-1:0] tx_data;
    logic              tx_sop;
    logic              tx_eop;

    modport master (
        output tok_valid, tok_pid, tok_addr, tok_endp, tx_ready,
        input  tok_ready, tx_valid, tx_data, tx_sop, tx_eop
    );

    modport slave (
        input  tok_valid, tok_pid, tok_addr, tok_endp, tx_ready,
        output tok_ready, tx_valid, tx_data, tx_sop, tx_eop
    );
endinterface

// File: rtl/usb_token_tx.sv
// USB token packet builder and serializer.
// Accepts {PID, ADDR, ENDP}, runs the 11-bit {endp,addr} field through an
// external crc5 block (re-seeded via crc_rst_n, one crc_en cycle), then sends
// the 24-bit token {crc, endp, addr, ~pid, pid} LSB-first in BEAT_W-bit beats.
// Optional build macro USB_TOKEN_PID_CHECK_EN: PIDs outside {1,5,9,D} are
// consumed without any crc/tx activity and flagged with a one-cycle pid_err.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | tok_ready high, waiting for a token request
// S_INIT  | crc_rst_n low: crc5 reloads its seed
// S_CALC  | crc_en high: crc5 absorbs crc_data at the end of this cycle
// S_WAIT  | crc_in is settled; shift register is loaded at the end
// S_SHIFT | tx_valid high; one beat leaves per tx_ready handshake
module usb_token_tx #(
    parameter int BEAT_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    usb_token_tx_if.slave       bus,
    output logic                crc_rst_n,
    output logic                crc_en,
    output logic [10:0]         crc_data,
    input  logic [4:0]          crc_in,
    output logic                pid_err
);

    localparam int NBEAT = 24 / BEAT_W;
    localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CALC,
        S_WAIT,
        S_SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic [10:0]      crc_data_q, crc_data_d;
    logic             crc_rst_n_q, crc_rst_n_d;
    logic             crc_en_q, crc_en_d;
    logic             pid_err_q, pid_err_d;
    logic [23:0]      shift_q, shift_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             pid_ok;
    logic [4:0]       crc_tx;

    // Remainder goes out complemented with crc_in[4] first on the wire.
    assign crc_tx = ~{crc_in[0], crc_in[1], crc_in[2], crc_in[3], crc_in[4]};

    // PID acceptance filter; without the check every PID is a token.
    always_comb begin
`ifdef USB_TOKEN_PID_CHECK_EN
        pid_ok = (bus.tok_pid == 4'h1) || (bus.tok_pid == 4'h5) ||
                 (bus.tok_pid == 4'h9) || (bus.tok_pid == 4'hD);
`else
        pid_ok = 1'b1;
`endif
    end

    // Next-state and registered-output logic for the token sequencer.
    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        crc_data_d  = crc_data_q;
        crc_rst_n_d = 1'b1;
        crc_en_d    = 1'b0;
        pid_err_d   = 1'b0;
        shift_d     = shift_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.tok_valid) begin
                    if (pid_ok) begin
                        pid_d       = bus.tok_pid;
                        crc_data_d  = {bus.tok_endp, bus.tok_addr};
                        crc_rst_n_d = 1'b0;
                        state_d     = S_INIT;
                    end else begin
                        pid_err_d   = 1'b1;
                    end
                end
            end
            S_INIT: begin
                crc_en_d = 1'b1;
                state_d  = S_CALC;
            end
            S_CALC: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // crc_data_q already holds {endp, addr} in packet order.
                shift_d    = {crc_tx, crc_data_q, ~pid_q, pid_q};
                beat_cnt_d = LAST_BEAT;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.tx_ready) begin
                    shift_d = shift_q >> BEAT_W;
                    if (beat_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pid_q       <= 4'h0;
            crc_data_q  <= 11'h000;
            crc_rst_n_q <= 1'b1;
            crc_en_q    <= 1'b0;
            pid_err_q   <= 1'b0;
            shift_q     <= 24'h000000;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            crc_data_q  <= crc_data_d;
            crc_rst_n_q <= crc_rst_n_d;
            crc_en_q    <= crc_en_d;
            pid_err_q   <= pid_err_d;
            shift_q     <= shift_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign bus.tok_ready = (state_q == S_IDLE);
    assign bus.tx_valid  = (state_q == S_SHIFT);
    assign bus.tx_data   = shift_q[BEAT_W-1:0];
    assign bus.tx_sop    = (state_q == S_SHIFT) && (beat_cnt_q == LAST_BEAT);
    assign bus.tx_eop    = (state_q == S_SHIFT) && (beat_cnt_q == '0);

    assign crc_rst_n = crc_rst_n_q;
    assign crc_en    = crc_en_q;
    assign crc_data  = crc_data_q;
    assign pid_err   = pid_err_q;

endmodule

// File: tb/tb_usb_token_tx.sv
// Testbench for usb_token_tx (BEAT_W = 8): a crc5 stand-in, a cycle-level
// reference model of the token timeline and wire bit order, directed cases
// and a randomized token/back-pressure phase.
module tb_usb_token_tx;

    localparam int BEAT_W = 8;
    localparam int NBEAT  = 24 / BEAT_W;
    localparam int BW2    = BEAT_W + 2;

    logic        clk;
    logic        rst;
    logic        crc_rst_n;
    logic        crc_en;
    logic [10:0] crc_data;
    logic [4:0]  crc_in;
    logic        pid_err;

    usb_token_tx_if #(.BEAT_W(BEAT_W)) bus ();

    usb_token_tx #(.BEAT_W(BEAT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .crc_rst_n (crc_rst_n),
        .crc_en    (crc_en),
        .crc_data  (crc_data),
        .crc_in    (crc_in),
        .pid_err   (pid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // USB CRC5 (x^5+x^2+1), data bits taken LSB first.
    function automatic logic [4:0] crc5_of(input logic [10:0] d, input logic [4:0] seed);
        logic [4:0] c;
        logic       fb;
        c = seed;
        for (int i = 0; i < 11; i++) begin
            fb = d[i] ^ c[4];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'h05;
        end
        return c;
    endfunction

    // crc5 stand-in: async reseed on crc_rst_n, absorb crc_data on crc_en.
    logic       force_crc;
    logic [4:0] crc_reg;
    always @(posedge clk or negedge crc_rst_n) begin
        if (!crc_rst_n)  crc_reg <= 5'h1F;
        else if (crc_en) crc_reg <= crc5_of(crc_data, crc_reg);
    end
    assign crc_in = force_crc ? 5'h0A : crc_reg;

    // Reference model state.
    int               mk = 0;          // cycles since accept, 0 = idle
    int               beats_left = 0;
    int               cyc = 0;
    int               n_acc = 0;
    int               acc_cyc[$];
    logic [BW2-1:0]   exp_q[$];
    logic [BW2-1:0]   got_q[$];
    logic [10:0]      exp_crc_data = '0;
    logic             exp_pid_err = 1'b0;

    function automatic logic pid_legal(input logic [3:0] pid);
`ifdef USB_TOKEN_PID_CHECK_EN
        return (pid == 4'h1) || (pid == 4'h5) || (pid == 4'h9) || (pid == 4'hD);
`else
        return 1'b1;
`endif
    endfunction

    // Lay out the token bit by bit in wire order, then cut into beats.
    task automatic push_token(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp, input logic [4:0] crc);
        logic wire_bits[$];
        for (int i = 0; i < 4; i++) wire_bits.push_back(pid[i]);
        for (int i = 0; i < 4; i++) wire_bits.push_back(~pid[i]);
        for (int i = 0; i < 7; i++) wire_bits.push_back(addr[i]);
        for (int i = 0; i < 4; i++) wire_bits.push_back(endp[i]);
        for (int i = 4; i >= 0; i--) wire_bits.push_back(~crc[i]);
        for (int b = 0; b < NBEAT; b++) begin
            logic [BEAT_W-1:0] d;
            d = '0;
            for (int j = 0; j < BEAT_W; j++) d[j] = wire_bits[b*BEAT_W + j];
            exp_q.push_back({(b == 0), (b == NBEAT-1), d});
        end
    endtask

    // Per-cycle model: check outputs, then advance on the upcoming edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mk = 0;
            beats_left = 0;
            exp_q.delete();
            exp_crc_data = '0;
            exp_pid_err = 1'b0;
        end else begin
            check_eq("tok_ready", bus.tok_ready, (mk == 0));
            check_eq("tx_valid", bus.tx_valid, (mk >= 4));
            check_eq("crc_rst_n", crc_rst_n, (mk != 1));
            check_eq("crc_en", crc_en, (mk == 2));
            check_eq("crc_data", crc_data, exp_crc_data);
            check_eq("pid_err", pid_err, exp_pid_err);
            exp_pid_err = 1'b0;
            if (mk >= 4) begin
                if (exp_q.size() > 0)
                    check_eq("beat", {bus.tx_sop, bus.tx_eop, bus.tx_data}, exp_q[0]);
                if (bus.tx_ready) begin
                    got_q.push_back({bus.tx_sop, bus.tx_eop, bus.tx_data});
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    beats_left--;
                    if (beats_left == 0) mk = 0;
                end
            end else if (mk > 0) begin
                mk++;
            end else if (bus.tok_valid) begin
                if (pid_legal(bus.tok_pid)) begin
                    mk = 1;
                    beats_left = NBEAT;
                    exp_crc_data = {bus.tok_endp, bus.tok_addr};
                    push_token(bus.tok_pid, bus.tok_addr, bus.tok_endp,
                               force_crc ? 5'h0A : crc5_of({bus.tok_endp, bus.tok_addr}, 5'h1F));
                    n_acc++;
                    acc_cyc.push_back(cyc);
                end else begin
                    exp_pid_err = 1'b1;
                end
            end
        end
    end

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        int n;
        bus.tok_pid   = pid;
        bus.tok_addr  = addr;
        bus.tok_endp  = endp;
        bus.tok_valid = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.tok_ready) break;
            n++;
        end
        check_eq("send_timeout", (n < 200), 1'b1);
        @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (mk != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, (n < 500), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tok_ready"}, bus.tok_ready, 1'b1);
        check_eq({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
        check_eq({tag, "_tx_sop"}, bus.tx_sop, 1'b0);
        check_eq({tag, "_tx_eop"}, bus.tx_eop, 1'b0);
        check_eq({tag, "_tx_data"}, bus.tx_data, '0);
        check_eq({tag, "_crc_rst_n"}, crc_rst_n, 1'b1);
        check_eq({tag, "_crc_en"}, crc_en, 1'b0);
        check_eq({tag, "_crc_data"}, crc_data, 11'h000);
        check_eq({tag, "_pid_err"}, pid_err, 1'b0);
    endtask

    task automatic check_example_beats(input string tag);
        check_eq({tag, "_nbeats"}, got_q.size(), 3);
        if (got_q.size() == 3) begin
            check_eq({tag, "_b0"}, got_q[0], {1'b1, 1'b0, 8'h69});
            check_eq({tag, "_b1"}, got_q[1], {1'b0, 1'b0, 8'h15});
            check_eq({tag, "_b2"}, got_q[2], {1'b0, 1'b1, 8'hAF});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic [3:0] legal_pids [4];
        int         n0;
        int         n;
        legal_pids = '{4'h1, 4'h5, 4'h9, 4'hD};

        rst           = 1'b0;
        force_crc     = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_pid   = 4'h0;
        bus.tok_addr  = 7'h00;
        bus.tok_endp  = 4'h0;
        bus.tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Known example with a fixed remainder, no back-pressure.
        force_crc    = 1'b1;
        bus.tx_ready = 1'b1;
        got_q.delete();
        send_token(4'h9, 7'h15, 4'hE);
        wait_idle("ex_idle");
        check_eq("ex_crc_data", crc_data, 11'h715);
        check_example_beats("ex");

        // Same token, beat 2 stalled for 5 cycles.
        got_q.delete();
        send_token(4'h9, 7'h15, 4'hE);
        repeat (4) @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        wait_idle("stall_idle");
        check_example_beats("stall");
        force_crc = 1'b0;

        // Reset while stalled in SHIFT, then a clean token.
        bus.tx_ready = 1'b0;
        send_token(4'h1, 7'h3A, 4'h2);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        bus.tx_ready = 1'b1;
        got_q.delete();
        @(posedge clk);
        #1;
        send_token(4'h5, 7'h7F, 4'h0);
        wait_idle("post_rst_idle");
        check_eq("post_rst_nbeats", got_q.size(), NBEAT);
        if (got_q.size() > 0) check_eq("post_rst_sop", got_q[0][BW2-1], 1'b1);

        // Back-to-back tokens with tok_valid held.
        n0 = n_acc;
        bus.tok_pid   = 4'hD;
        bus.tok_addr  = 7'h01;
        bus.tok_endp  = 4'h1;
        bus.tok_valid = 1'b1;
        n = 0;
        while (n_acc < n0 + 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.tok_valid = 1'b0;
        check_eq("b2b_timeout", (n < 200), 1'b1);
        wait_idle("b2b_idle");
        if (acc_cyc.size() >= 3) begin
            check_eq("b2b_period1", acc_cyc[acc_cyc.size()-2] - acc_cyc[acc_cyc.size()-3], 4 + NBEAT);
            check_eq("b2b_period2", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 4 + NBEAT);
        end

`ifdef USB_TOKEN_PID_CHECK_EN
        // Illegal PID is consumed with an error pulse, then a legal one.
        n0 = n_acc;
        send_token(4'h4, 7'h11, 4'h3);
        repeat (3) @(posedge clk);
        #1;
        check_eq("badpid_no_token", n_acc - n0, 0);
        got_q.delete();
        send_token(4'hD, 7'h11, 4'h3);
        wait_idle("goodpid_idle");
        check_eq("goodpid_nbeats", got_q.size(), NBEAT);
`endif

        // Randomized tokens and back-pressure.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            acc = bus.tok_valid && bus.tok_ready;
            @(posedge clk);
            #1;
            if (acc) bus.tok_valid = 1'b0;
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            if (!bus.tok_valid && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    bus.tok_pid = legal_pids[$urandom_range(0, 3)];
                else
                    bus.tok_pid = 4'($urandom_range(0, 15));
                bus.tok_addr  = 7'($urandom_range(0, 127));
                bus.tok_endp  = 4'($urandom_range(0, 15));
                bus.tok_valid = 1'b1;
            end
        end
        @(negedge clk);
        acc = bus.tok_valid && bus.tok_ready;
        @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        wait_idle("rand_idle");
        check_eq("rand_exp_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
